fetch_decode_buf: RTL and testbench

FETCH_DECODE_BUF -- requirements
Module: fetch_decode_buf

---
 rtl/fd_pkg.sv | 23 ++
 rtl/fd_sat_counter.sv | 32 +++
 rtl/fetch_decode_buf.sv | 136 +++++++++++++
 tb/tb_fetch_decode_buf.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch/decode buffer.
// Default widths, NOP encoding, FIFO state enum and entry layout.
package fd_pkg;

  localparam int FD_IWIDTH = 24;
  localparam int FD_PWIDTH = 16;
  localparam int FD_CNT_W  = 16;

  localparam logic [FD_IWIDTH-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fd_state_t;

  typedef struct packed {
    logic [FD_IWIDTH-1:0] instr;
    logic [FD_PWIDTH-1:0] pc;
    logic [FD_PWIDTH-1:0] next_pc;
  } fd_entry_t;

endpackage

// File: rtl/fd_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk_i, clr_i (sync clear), en_i (count), cnt_o (value).
module fd_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_decode_buf.sv
// 2-entry fetch->decode skid FIFO with flush and optional stats.
// Ports: clk_i, rst_i (sync, active-high), f_* (fetch side),
// d_* (decode side), flush_i, stall_cnt_o/flush_cnt_o.
// Define FD_BUF_STATS_EN to build the saturating stat counters.
module fetch_decode_buf
  import fd_pkg::*;
#(
  parameter int IWIDTH = FD_IWIDTH,
  parameter int PWIDTH = FD_PWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_valid_i,
  output logic              f_ready_o,
  input  logic [IWIDTH-1:0] f_instr_i,
  input  logic [PWIDTH-1:0] f_pc_i,
  input  logic [PWIDTH-1:0] f_next_pc_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [IWIDTH-1:0] d_instr_o,
  output logic [PWIDTH-1:0] d_pc_o,
  output logic [PWIDTH-1:0] d_next_pc_o,
  input  logic              flush_i,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
);

  // Entry layout at the instance widths.
  typedef struct packed {
    logic [IWIDTH-1:0] instr;
    logic [PWIDTH-1:0] pc;
    logic [PWIDTH-1:0] next_pc;
  } entry_t;

  fd_state_t state_d;
  fd_state_t state_q;
  entry_t    head_d;
  entry_t    head_q;
  entry_t    tail_d;
  entry_t    tail_q;
  entry_t    in_e;
  logic      push;
  logic      pop;

  assign f_ready_o = (state_q != FULL);
  assign d_valid_o = (state_q != EMPTY);

  assign push = f_valid_i & f_ready_o;
  assign pop  = d_valid_o & d_ready_i;

  assign in_e.instr   = f_instr_i;
  assign in_e.pc      = f_pc_i;
  assign in_e.next_pc = f_next_pc_i;

  // head_q is always the oldest entry; tail_q only matters in FULL.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_e;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_e;
          end else if (push) begin
            tail_d  = in_e;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Stale head data is masked so an empty buffer presents a NOP.
  assign d_instr_o   = d_valid_o ? head_q.instr : IWIDTH'(NOP_INSTR);
  assign d_pc_o      = d_valid_o ? head_q.pc : '0;
  assign d_next_pc_o = d_valid_o ? head_q.next_pc : '0;

`ifdef FD_BUF_STATS_EN
  logic stall_en;
  assign stall_en = d_valid_o & ~d_ready_i;

  fd_sat_counter #(
    .W(FD_CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (stall_en),
    .cnt_o (stall_cnt_o)
  );

  fd_sat_counter #(
    .W(FD_CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (flush_i),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_buf.sv
// Self-checking bench for fetch_decode_buf.
// Directed scenarios plus a queue-based random reference model.
module tb_fetch_decode_buf;
  import fd_pkg::*;

`ifdef FD_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        f_valid_i;
  logic        f_ready_o;
  logic [23:0] f_instr_i;
  logic [15:0] f_pc_i;
  logic [15:0] f_next_pc_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [23:0] d_instr_o;
  logic [15:0] d_pc_o;
  logic [15:0] d_next_pc_o;
  logic        flush_i;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  fetch_decode_buf #(
    .IWIDTH(24),
    .PWIDTH(16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .f_valid_i   (f_valid_i),
    .f_ready_o   (f_ready_o),
    .f_instr_i   (f_instr_i),
    .f_pc_i      (f_pc_i),
    .f_next_pc_i (f_next_pc_i),
    .d_valid_o   (d_valid_o),
    .d_ready_i   (d_ready_i),
    .d_instr_o   (d_instr_o),
    .d_pc_o      (d_pc_o),
    .d_next_pc_o (d_next_pc_o),
    .flush_i     (flush_i),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [15:0] pc);
    f_valid_i   = 1'b1;
    f_pc_i      = pc;
    f_next_pc_i = pc + 16'd4;
    f_instr_i   = {8'hA5, pc};
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    f_valid_i = 1'b0;
    d_ready_i = 1'b0;
    flush_i   = 1'b0;
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ntests++;
    if (d_valid_o !== 1'b0) begin
      nfail++;
      $display("FAIL rst_d_valid got %b exp 0", d_valid_o);
    end
    ntests++;
    if (f_ready_o !== 1'b1) begin
      nfail++;
      $display("FAIL rst_f_ready got %b exp 1", f_ready_o);
    end
    ntests++;
    if ({d_instr_o, d_pc_o, d_next_pc_o} !== 56'h0) begin
      nfail++;
      $display("FAIL rst_head got %h/%h/%h exp 0",
               d_instr_o, d_pc_o, d_next_pc_o);
    end
    ntests++;
    if ({stall_cnt_o, flush_cnt_o} !== 32'h0) begin
      nfail++;
      $display("FAIL rst_cnt got %h/%h exp 0",
               stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    f_valid_i   = 1'b1;
    f_instr_i   = 24'h123456;
    f_pc_i      = 16'h0000;
    f_next_pc_i = 16'h0004;
    d_ready_i   = 1'b1;
    cyc();
    f_valid_i = 1'b0;
    ntests++;
    if (d_valid_o !== 1'b1 || d_instr_o !== 24'h123456) begin
      nfail++;
      $display("FAIL single_vis got v=%b i=%h exp v=1 i=123456",
               d_valid_o, d_instr_o);
    end
    ntests++;
    if (d_next_pc_o !== 16'h0004) begin
      nfail++;
      $display("FAIL single_npc got %h exp 0004", d_next_pc_o);
    end
    cyc();
    ntests++;
    if (d_valid_o !== 1'b0) begin
      nfail++;
      $display("FAIL single_pop got %b exp 0", d_valid_o);
    end
  endtask

  task automatic test_full_drain();
    do_reset();
    offer(16'h0000);
    cyc();
    offer(16'h0004);
    cyc();
    f_valid_i = 1'b0;
    ntests++;
    if (f_ready_o !== 1'b0 || d_valid_o !== 1'b1 ||
        d_pc_o !== 16'h0000) begin
      nfail++;
      $display("FAIL full_state got rdy=%b v=%b pc=%h exp 0/1/0000",
               f_ready_o, d_valid_o, d_pc_o);
    end
    // Offer while full: must not be stored.
    offer(16'h0EEE);
    cyc();
    f_valid_i = 1'b0;
    ntests++;
    if (d_pc_o !== 16'h0000 || f_ready_o !== 1'b0) begin
      nfail++;
      $display("FAIL full_hold got pc=%h rdy=%b exp 0000/0",
               d_pc_o, f_ready_o);
    end
    d_ready_i = 1'b1;
    cyc();
    ntests++;
    if (d_pc_o !== 16'h0004 || f_ready_o !== 1'b1) begin
      nfail++;
      $display("FAIL full_pop got pc=%h rdy=%b exp 0004/1",
               d_pc_o, f_ready_o);
    end
    cyc();
    d_ready_i = 1'b0;
    ntests++;
    if (d_valid_o !== 1'b0) begin
      nfail++;
      $display("FAIL full_drain got v=%b exp 0", d_valid_o);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    offer(16'h0008);
    cyc();
    ntests++;
    if (d_pc_o !== 16'h0008) begin
      nfail++;
      $display("FAIL pp_head got %h exp 0008", d_pc_o);
    end
    offer(16'h000C);
    d_ready_i = 1'b1;
    cyc();
    f_valid_i = 1'b0;
    d_ready_i = 1'b0;
    ntests++;
    if (d_pc_o !== 16'h000C || d_valid_o !== 1'b1 ||
        f_ready_o !== 1'b1) begin
      nfail++;
      $display("FAIL pp_one got pc=%h v=%b rdy=%b exp 000c/1/1",
               d_pc_o, d_valid_o, f_ready_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    offer(16'h0010);
    cyc();
    offer(16'h0014);
    cyc();
    flush_i = 1'b1;
    offer(16'h0018);
    cyc();
    flush_i   = 1'b0;
    f_valid_i = 1'b0;
    ntests++;
    if (d_valid_o !== 1'b0 || f_ready_o !== 1'b1 ||
        d_instr_o !== 24'h0) begin
      nfail++;
      $display("FAIL flush_out got v=%b rdy=%b i=%h exp 0/1/0",
               d_valid_o, f_ready_o, d_instr_o);
    end
    ntests++;
    if (flush_cnt_o !== (STATS ? 16'd1 : 16'd0)) begin
      nfail++;
      $display("FAIL flush_cnt got %0d exp %0d",
               flush_cnt_o, STATS ? 1 : 0);
    end
  endtask

  task automatic test_reset_full();
    do_reset();
    offer(16'h0020);
    cyc();
    offer(16'h0024);
    cyc();
    rst_i   = 1'b1;
    flush_i = 1'b1;
    offer(16'h0028);
    d_ready_i = 1'b1;
    cyc();
    rst_i     = 1'b0;
    flush_i   = 1'b0;
    f_valid_i = 1'b0;
    d_ready_i = 1'b0;
    ntests++;
    if (d_valid_o !== 1'b0 || f_ready_o !== 1'b1 ||
        {d_instr_o, d_pc_o, d_next_pc_o} !== 56'h0) begin
      nfail++;
      $display("FAIL rstfull_out got v=%b rdy=%b pc=%h exp 0/1/0",
               d_valid_o, f_ready_o, d_pc_o);
    end
    ntests++;
    if ({stall_cnt_o, flush_cnt_o} !== 32'h0) begin
      nfail++;
      $display("FAIL rstfull_cnt got %h/%h exp 0",
               stall_cnt_o, flush_cnt_o);
    end
  endtask

  // Reference: a plain queue of at most two entries.
  task automatic test_random();
    fd_entry_t q[$];
    fd_entry_t e;
    int m_stall = 0;
    int m_flush = 0;
    bit m_valid;
    bit m_ready;
    int errs = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      f_valid_i   = ($urandom_range(3) != 0);
      d_ready_i   = ($urandom_range(2) != 0);
      flush_i     = ($urandom_range(15) == 0);
      f_instr_i   = 24'($urandom);
      f_pc_i      = 16'($urandom);
      f_next_pc_i = 16'($urandom);
      m_valid = (q.size() != 0);
      m_ready = (q.size() < 2);
      if (m_valid && !d_ready_i && m_stall < 65535) m_stall++;
      if (flush_i && m_flush < 65535) m_flush++;
      if (flush_i) begin
        q.delete();
      end else begin
        if (m_valid && d_ready_i) void'(q.pop_front());
        if (f_valid_i && m_ready) begin
          e.instr   = f_instr_i;
          e.pc      = f_pc_i;
          e.next_pc = f_next_pc_i;
          q.push_back(e);
        end
      end
      cyc();
      if (q.size() != 0) e = q[0];
      else e = '0;
      ntests++;
      if (d_valid_o !== (q.size() != 0) ||
          f_ready_o !== (q.size() != 2)) begin
        nfail++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_hs n=%0d got v=%b r=%b exp size %0d",
                   n, d_valid_o, f_ready_o, q.size());
      end
      ntests++;
      if ({d_instr_o, d_pc_o, d_next_pc_o} !== e) begin
        nfail++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_head n=%0d got %h/%h/%h exp %h",
                   n, d_instr_o, d_pc_o, d_next_pc_o, e);
      end
      ntests++;
      if (stall_cnt_o !== (STATS ? 16'(m_stall) : 16'h0) ||
          flush_cnt_o !== (STATS ? 16'(m_flush) : 16'h0)) begin
        nfail++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_cnt n=%0d got %0d/%0d exp %0d/%0d",
                   n, stall_cnt_o, flush_cnt_o,
                   STATS ? m_stall : 0, STATS ? m_flush : 0);
      end
    end
    f_valid_i = 1'b0;
    d_ready_i = 1'b0;
    flush_i   = 1'b0;
  endtask

  task automatic test_stall_sat();
    do_reset();
    offer(16'h0040);
    cyc();
    f_valid_i = 1'b0;
    repeat (65534) cyc();
    ntests++;
    if (stall_cnt_o !== (STATS ? 16'hFFFE : 16'h0)) begin
      nfail++;
      $display("FAIL stall_pre got %h exp %h",
               stall_cnt_o, STATS ? 16'hFFFE : 16'h0);
    end
    cyc();
    ntests++;
    if (stall_cnt_o !== (STATS ? 16'hFFFF : 16'h0)) begin
      nfail++;
      $display("FAIL stall_sat got %h exp %h",
               stall_cnt_o, STATS ? 16'hFFFF : 16'h0);
    end
    repeat (4465) cyc();
    ntests++;
    if (stall_cnt_o !== (STATS ? 16'hFFFF : 16'h0) ||
        d_pc_o !== 16'h0040) begin
      nfail++;
      $display("FAIL stall_nowrap got %h pc=%h exp %h pc=0040",
               stall_cnt_o, d_pc_o, STATS ? 16'hFFFF : 16'h0);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    f_valid_i   = 1'b0;
    d_ready_i   = 1'b0;
    flush_i     = 1'b0;
    f_instr_i   = '0;
    f_pc_i      = '0;
    f_next_pc_i = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_full_drain();
    test_push_pop();
    test_flush();
    test_reset_full();
    test_random();
    test_stall_sat();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
